// File: rtl/fifo_ctrl8_pkg.sv
// rtl/fifo_ctrl8_pkg.sv - shared sizes and FSM state encoding for the 8-entry FIFO control path
package fifo_ctrl8_pkg;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  // Each state records which operation happened on the last clock edge
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_WRITE  = 3'd2,
    S_WR_ERR = 3'd3,
    S_READ   = 3'd4,
    S_RD_ERR = 3'd5,
    S_RDWR   = 3'd6
  } state_t;
endpackage

// File: rtl/fifo_ctrl8_ns.sv
// rtl/fifo_ctrl8_ns.sv - combinational next-state, next pointers and next count
// Ports:
//   i_wr_req, i_rd_req       requests for this cycle
//   i_full, i_empty          occupancy status from the registered count
//   i_wr_ptr, i_rd_ptr       current pointers
//   i_count                  current occupancy
//   o_wr_ok, o_rd_ok         operation accepted this cycle
//   o_state_nxt              next FSM state
//   o_wr_err_x_nxt           wr_err raised alongside a successful read
//   o_rd_err_x_nxt           rd_err raised alongside a successful write
//   o_wr_ptr_nxt, o_rd_ptr_nxt, o_count_nxt
module fifo_ctrl8_ns
  import fifo_ctrl8_pkg::*;
(
  input  logic          i_wr_req,
  input  logic          i_rd_req,
  input  logic          i_full,
  input  logic          i_empty,
  input  logic [AW-1:0] i_wr_ptr,
  input  logic [AW-1:0] i_rd_ptr,
  input  logic [CW-1:0] i_count,
  output logic          o_wr_ok,
  output logic          o_rd_ok,
  output state_t        o_state_nxt,
  output logic          o_wr_err_x_nxt,
  output logic          o_rd_err_x_nxt,
  output logic [AW-1:0] o_wr_ptr_nxt,
  output logic [AW-1:0] o_rd_ptr_nxt,
  output logic [CW-1:0] o_count_nxt
);
  // A write while full is rejected even if a read frees a slot on the same edge
  assign o_wr_ok = i_wr_req & ~i_full;
  assign o_rd_ok = i_rd_req & ~i_empty;

  // Pointer width equals log2(DEPTH), so the 7->0 wrap is the natural overflow
  assign o_wr_ptr_nxt = o_wr_ok ? i_wr_ptr + AW'(1) : i_wr_ptr;
  assign o_rd_ptr_nxt = o_rd_ok ? i_rd_ptr + AW'(1) : i_rd_ptr;

  always_comb begin
    o_count_nxt = i_count;
    case ({o_wr_ok, o_rd_ok})
      2'b10:   o_count_nxt = i_count + CW'(1);
      2'b01:   o_count_nxt = i_count - CW'(1);
      default: o_count_nxt = i_count;
    endcase
  end

  always_comb begin
    o_state_nxt    = S_IDLE;
    o_wr_err_x_nxt = 1'b0;
    o_rd_err_x_nxt = 1'b0;
    case ({i_wr_req, i_rd_req})
      2'b10: o_state_nxt = i_full  ? S_WR_ERR : S_WRITE;
      2'b01: o_state_nxt = i_empty ? S_RD_ERR : S_READ;
      2'b11: begin
        if (i_empty) begin
          // No bypass: the write lands, the read sees an empty FIFO
          o_state_nxt    = S_WRITE;
          o_rd_err_x_nxt = 1'b1;
        end else if (i_full) begin
          o_state_nxt    = S_READ;
          o_wr_err_x_nxt = 1'b1;
        end else begin
          o_state_nxt = S_RDWR;
        end
      end
      default: o_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: rtl/fifo_ctrl8.sv
// rtl/fifo_ctrl8.sv - control path of the 8x32 FIFO: pointers, count, FSM, bank write enables
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   wr_req, rd_req        operation requests sampled at posedge
//   we_oh                 one-hot bank write enable (combinational, entry = wr_ptr)
//   rd_sel                read-mux select = rd_ptr
//   data_count            stored words 0..8
//   full, empty           occupancy status
//   wr_ack, wr_err        write outcome of the previous edge
//   rd_ack, rd_err        read outcome of the previous edge
module fifo_ctrl8
  import fifo_ctrl8_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic [DEPTH-1:0] we_oh,
  output logic [AW-1:0]    rd_sel,
  output logic [CW-1:0]    data_count,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
);
  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_wr_err_x;
  logic          r_rd_err_x;

  state_t        w_state_nxt;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_wr_err_x_nxt;
  logic          w_rd_err_x_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;

  assign full       = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign data_count = r_count;
  assign rd_sel     = r_rd_ptr;

  // Gated by reset_n so an in-flight enable drops the moment reset asserts
  assign we_oh = (w_wr_ok && reset_n) ? (DEPTH'(1) << r_wr_ptr) : '0;

  fifo_ctrl8_ns u_ns (
    .i_wr_req       (wr_req),
    .i_rd_req       (rd_req),
    .i_full         (full),
    .i_empty        (empty),
    .i_wr_ptr       (r_wr_ptr),
    .i_rd_ptr       (r_rd_ptr),
    .i_count        (r_count),
    .o_wr_ok        (w_wr_ok),
    .o_rd_ok        (w_rd_ok),
    .o_state_nxt    (w_state_nxt),
    .o_wr_err_x_nxt (w_wr_err_x_nxt),
    .o_rd_err_x_nxt (w_rd_err_x_nxt),
    .o_wr_ptr_nxt   (w_wr_ptr_nxt),
    .o_rd_ptr_nxt   (w_rd_ptr_nxt),
    .o_count_nxt    (w_count_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_err_x <= 1'b0;
      r_rd_err_x <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_wr_err_x <= w_wr_err_x_nxt;
      r_rd_err_x <= w_rd_err_x_nxt;
    end
  end

  // Moore flag decode; the _x bits add the rejected half of a simultaneous request
  always_comb begin
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    wr_err = r_wr_err_x;
    rd_err = r_rd_err_x;
    case (r_state)
      S_WRITE:  wr_ack = 1'b1;
      S_WR_ERR: wr_err = 1'b1;
      S_READ:   rd_ack = 1'b1;
      S_RD_ERR: rd_err = 1'b1;
      S_RDWR: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fifo_ctrl8.sv
// tb/tb_fifo_ctrl8.sv - scoreboard bench for fifo_ctrl8 with a behavioural occupancy model
module tb_fifo_ctrl8;
  logic       clk;
  logic       reset_n;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] we_oh;
  logic [2:0] rd_sel;
  logic [3:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

  fifo_ctrl8 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .we_oh      (we_oh),
    .rd_sel     (rd_sel),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] we_oh;
    logic [2:0] rd_sel;
    logic [3:0] count;
    logic       full, empty, wack, werr, rack, rerr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_no   = 0;

  // Reference model: occupancy and slot indices as plain integers
  int m_count, m_wr, m_rd;
  bit m_wack, m_werr, m_rack, m_rerr;

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_rd = 0;
    m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
  endtask

  // Drive one cycle of requests, record the outputs expected before the edge, then advance the model
  task automatic cycle(input bit w, input bit r);
    exp_t e;
    bit wok, rok;
    @(posedge clk);
    #1;
    wr_req = w;
    rd_req = r;
    cyc_no++;
    wok = w && (m_count < 8);
    rok = r && (m_count > 0);
    e.cyc    = cyc_no;
    e.we_oh  = wok ? 8'(1 << m_wr) : 8'h00;
    e.rd_sel = 3'(m_rd);
    e.count  = 4'(m_count);
    e.full   = (m_count == 8);
    e.empty  = (m_count == 0);
    e.wack   = m_wack;
    e.werr   = m_werr;
    e.rack   = m_rack;
    e.rerr   = m_rerr;
    exp_q.push_back(e);
    if (wok) m_wr = (m_wr + 1) % 8;
    if (rok) m_rd = (m_rd + 1) % 8;
    m_count = m_count + int'(wok) - int'(rok);
    m_wack = wok;
    m_werr = w && !wok;
    m_rack = rok;
    m_rerr = r && !rok;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("we_oh",      e.cyc, 32'(we_oh),      32'(e.we_oh));
        chk("rd_sel",     e.cyc, 32'(rd_sel),     32'(e.rd_sel));
        chk("data_count", e.cyc, 32'(data_count), 32'(e.count));
        chk("full",       e.cyc, 32'(full),       32'(e.full));
        chk("empty",      e.cyc, 32'(empty),      32'(e.empty));
        chk("wr_ack",     e.cyc, 32'(wr_ack),     32'(e.wack));
        chk("wr_err",     e.cyc, 32'(wr_err),     32'(e.werr));
        chk("rd_ack",     e.cyc, 32'(rd_ack),     32'(e.rack));
        chk("rd_err",     e.cyc, 32'(rd_err),     32'(e.rerr));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, cyc_no, 32'(data_count), 32'd0);
    chk({tag, "_we_oh"}, cyc_no, 32'(we_oh),      32'd0);
    chk({tag, "_empty"}, cyc_no, 32'(empty),      32'd1);
    chk({tag, "_full"},  cyc_no, 32'(full),       32'd0);
    chk({tag, "_flags"}, cyc_no, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
    chk({tag, "_rdsel"}, cyc_no, 32'(rd_sel),     32'd0);
  endtask

  initial begin
    int p_w, p_r, wait_cnt;
    reset_n = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Idle after reset
    repeat (3) cycle(0, 0);
    // Fill, overfill
    repeat (8) cycle(1, 0);
    cycle(1, 0);
    cycle(0, 0);
    // Drain past empty
    repeat (9) cycle(0, 1);
    cycle(0, 0);
    // Move pointers so simultaneous traffic wraps 7->0
    repeat (5) cycle(1, 0);
    repeat (5) cycle(0, 1);
    repeat (3) cycle(1, 0);
    repeat (4) cycle(1, 1);
    cycle(0, 0);
    repeat (3) cycle(0, 1);
    // Simultaneous on empty, then simultaneous on full
    cycle(1, 1);
    repeat (7) cycle(1, 0);
    cycle(1, 1);
    cycle(0, 0);

    // Randomized phases with varying write/read bias
    for (int ph = 0; ph < 8; ph++) begin
      p_w = $urandom_range(10, 90);
      p_r = $urandom_range(10, 90);
      for (int i = 0; i < 40; i++)
        cycle(($urandom % 100) < p_w, ($urandom % 100) < p_r);
    end

    // Reset in the middle of a burst
    repeat (3) cycle(0, 1);
    repeat (5) cycle(0, 1);
    cycle(1, 1);
    cycle(1, 0);
    #6;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1;
    check_reset_outputs("midrst_hold");
    reset_n = 1'b1;
    model_reset();
    repeat (2) cycle(0, 0);
    repeat (3) cycle(1, 0);
    cycle(0, 0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
